// File: rtl/dc_sweep_pkg.sv
// Shared types for the DC sweep sequencer.
//   sweep_state_e : sequencer FSM states
//   sweep_rec_t   : one streamed measurement record (default widths)
package dc_sweep_pkg;

    localparam int unsigned DefIdxW = 8;
    localparam int unsigned DefAdcW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StConvert,
        StEmit,
        StDone
    } sweep_state_e;

    typedef struct packed {
        logic [DefIdxW-1:0] vgs_idx;
        logic [DefIdxW-1:0] vds_idx;
        logic [DefAdcW-1:0] id;
    } sweep_rec_t;

endpackage

// File: rtl/dc_sweep_sequencer_if.sv
// ADC handshake and record stream of the DC sweep sequencer.
//   master : sequencer side (drives adc_req and the record stream)
//   slave  : front-end / sink side (drives adc_ack, adc_data, out_ready)
// adc_data and out_id carry two's complement currents.
interface dc_sweep_sequencer_if #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned ADC_W = 16
) ();

    logic             adc_req;
    logic             adc_ack;
    logic [ADC_W-1:0] adc_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_vgs_idx;
    logic [IDX_W-1:0] out_vds_idx;
    logic [ADC_W-1:0] out_id;

    modport master (
        output adc_req,
        input  adc_ack,
        input  adc_data,
        output out_valid,
        input  out_ready,
        output out_vgs_idx,
        output out_vds_idx,
        output out_id
    );

    modport slave (
        input  adc_req,
        output adc_ack,
        output adc_data,
        input  out_valid,
        output out_ready,
        input  out_vgs_idx,
        input  out_vds_idx,
        input  out_id
    );

endinterface

// File: rtl/sweep_axis_cnt.sv
// One sweep axis: point index and DAC code with shadowed start/step/num.
//   cfg_load_i : capture start/step/num, restart at index 0 / start code
//   adv_i      : next point (index+1, code+step)
//   wrap_i     : back to index 0 / shadowed start code
//   last_o     : current index is the final point
//   carry_o    : code+step would leave the CODE_W range
module sweep_axis_cnt #(
    parameter int unsigned CODE_W = 12,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load_i,
    input  logic              adv_i,
    input  logic              wrap_i,
    input  logic [CODE_W-1:0] start_i,
    input  logic [CODE_W-1:0] step_i,
    input  logic [IDX_W-1:0]  num_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic [CODE_W-1:0] code_o,
    output logic              last_o,
    output logic              carry_o
);

    localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

    logic [CODE_W-1:0] start_q, step_q, code_q;
    logic [IDX_W-1:0]  num_q, idx_q;
    logic [CODE_W:0]   sum;

    assign sum     = {1'b0, code_q} + {1'b0, step_q};
    assign carry_o = sum[CODE_W];
    assign last_o  = (idx_q == (num_q - IdxOne));
    assign idx_o   = idx_q;
    assign code_o  = code_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            step_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
        end else if (cfg_load_i) begin
            start_q <= start_i;
            step_q  <= step_i;
            num_q   <= num_i;
            idx_q   <= '0;
            code_q  <= start_i;
        end else if (adv_i) begin
            idx_q  <= idx_q + IdxOne;
            code_q <= sum[CODE_W-1:0];
        end else if (wrap_i) begin
            idx_q  <= '0;
            code_q <= start_q;
        end
    end

endmodule

// File: rtl/dc_sweep_sequencer.sv
// Two-level DC sweep sequencer: outer Vgs, inner Vds. Loads both DAC codes, waits
// settle_cyc cycles, requests one conversion and streams (vgs_idx, vds_idx, -I_probe).
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : sweep control pulses
//   vgs_*/vds_*       : axis start code, step, point count (sampled on start)
//   settle_cyc        : settle wait after each DAC load
//   dac_vgs/dac_vds   : DAC codes, dac_load strobes with each change
//   bus               : ADC req/ack handshake and valid/ready record stream
//   busy, done, err   : status; err flags a DAC code overflow
module dc_sweep_sequencer
    import dc_sweep_pkg::*;
#(
    parameter int unsigned CODE_W = 12,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned ADC_W  = 16,
    parameter int unsigned SET_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] vgs_start,
    input  logic [CODE_W-1:0] vgs_step,
    input  logic [IDX_W-1:0]  vgs_num,
    input  logic [CODE_W-1:0] vds_start,
    input  logic [CODE_W-1:0] vds_step,
    input  logic [IDX_W-1:0]  vds_num,
    input  logic [SET_W-1:0]  settle_cyc,
    output logic [CODE_W-1:0] dac_vgs,
    output logic [CODE_W-1:0] dac_vds,
    output logic              dac_load,
    dc_sweep_sequencer_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [SET_W-1:0] SetOne = SET_W'(1);
    localparam logic [ADC_W-1:0] AdcMin = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ADC_W-1:0] AdcMax = ~AdcMin;

    // Id = -I_probe; the most negative code has no positive twin, so clamp it.
    function automatic logic [ADC_W-1:0] neg_sat(input logic [ADC_W-1:0] d);
        return (d == AdcMin) ? AdcMax : (ADC_W'(0) - d);
    endfunction

    sweep_state_e      state_q, state_d;
    logic              err_q, err_d;
    logic [SET_W-1:0]  settle_cfg_q, settle_cnt_q, settle_cnt_d;
    logic [CODE_W-1:0] dac_vgs_q, dac_vds_q;
    logic              dac_load_q;
    logic [IDX_W-1:0]  out_vgs_idx_q, out_vds_idx_q;
    logic [ADC_W-1:0]  out_id_q;

    logic              cfg_load, vgs_adv, vds_adv, vds_wrap, dac_upd, capture;
    logic [IDX_W-1:0]  vgs_idx, vds_idx;
    logic [CODE_W-1:0] vgs_code, vds_code;
    logic              vgs_last, vds_last, vgs_carry, vds_carry;

    sweep_axis_cnt #(.CODE_W(CODE_W), .IDX_W(IDX_W)) u_vgs_cnt (
        .clk        (clk),
        .rst        (rst),
        .cfg_load_i (cfg_load),
        .adv_i      (vgs_adv),
        .wrap_i     (1'b0),
        .start_i    (vgs_start),
        .step_i     (vgs_step),
        .num_i      (vgs_num),
        .idx_o      (vgs_idx),
        .code_o     (vgs_code),
        .last_o     (vgs_last),
        .carry_o    (vgs_carry)
    );

    sweep_axis_cnt #(.CODE_W(CODE_W), .IDX_W(IDX_W)) u_vds_cnt (
        .clk        (clk),
        .rst        (rst),
        .cfg_load_i (cfg_load),
        .adv_i      (vds_adv),
        .wrap_i     (vds_wrap),
        .start_i    (vds_start),
        .step_i     (vds_step),
        .num_i      (vds_num),
        .idx_o      (vds_idx),
        .code_o     (vds_code),
        .last_o     (vds_last),
        .carry_o    (vds_carry)
    );

    assign busy = (state_q != StIdle) && (state_q != StDone);
    assign done = (state_q == StDone);
    assign err  = err_q;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        settle_cnt_d = settle_cnt_q;
        cfg_load     = 1'b0;
        vgs_adv      = 1'b0;
        vds_adv      = 1'b0;
        vds_wrap     = 1'b0;
        dac_upd      = 1'b0;
        capture      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start && !abort) begin
                    cfg_load = 1'b1;
                    err_d    = 1'b0;
                    state_d  = ((vgs_num == '0) || (vds_num == '0)) ? StDone : StLoad;
                end
            end
            StLoad: begin
                dac_upd      = 1'b1;
                settle_cnt_d = settle_cfg_q;
                state_d      = (settle_cfg_q == '0) ? StConvert : StSettle;
            end
            StSettle: begin
                settle_cnt_d = settle_cnt_q - SetOne;
                if (settle_cnt_q == SetOne) state_d = StConvert;
            end
            StConvert: begin
                if (bus.adc_ack) begin
                    capture = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    if (!vds_last) begin
                        if (vds_carry) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            vds_adv = 1'b1;
                            state_d = StLoad;
                        end
                    end else if (!vgs_last) begin
                        if (vgs_carry) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            vgs_adv  = 1'b1;
                            vds_wrap = 1'b1;
                            state_d  = StLoad;
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides everything: no DAC update, no capture, no advance.
        if (abort && busy) begin
            state_d  = StDone;
            err_d    = 1'b0;
            vgs_adv  = 1'b0;
            vds_adv  = 1'b0;
            vds_wrap = 1'b0;
            dac_upd  = 1'b0;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            err_q         <= 1'b0;
            settle_cfg_q  <= '0;
            settle_cnt_q  <= '0;
            dac_vgs_q     <= '0;
            dac_vds_q     <= '0;
            dac_load_q    <= 1'b0;
            out_vgs_idx_q <= '0;
            out_vds_idx_q <= '0;
            out_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            settle_cnt_q <= settle_cnt_d;
            dac_load_q   <= dac_upd;
            if (cfg_load) settle_cfg_q <= settle_cyc;
            if (dac_upd) begin
                dac_vgs_q <= vgs_code;
                dac_vds_q <= vds_code;
            end
            if (capture) begin
                out_vgs_idx_q <= vgs_idx;
                out_vds_idx_q <= vds_idx;
                out_id_q      <= neg_sat(bus.adc_data);
            end
        end
    end

    assign dac_vgs         = dac_vgs_q;
    assign dac_vds         = dac_vds_q;
    assign dac_load        = dac_load_q;
    assign bus.adc_req     = (state_q == StConvert);
    assign bus.out_valid   = (state_q == StEmit);
    assign bus.out_vgs_idx = out_vgs_idx_q;
    assign bus.out_vds_idx = out_vds_idx_q;
    assign bus.out_id      = out_id_q;

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Self-checking bench for dc_sweep_sequencer: an ADC responder and a record sink run
// against a point-list reference model built from the sweep arithmetic.
module tb_dc_sweep_sequencer;
    import dc_sweep_pkg::*;

    localparam int unsigned CW = 12;
    localparam int unsigned IW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned SW = 16;
    localparam int          Budget = 5000;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] vgs_start, vgs_step, vds_start, vds_step;
    logic [IW-1:0] vgs_num, vds_num;
    logic [SW-1:0] settle_cyc;
    logic [CW-1:0] dac_vgs, dac_vds;
    logic          dac_load, busy, done, err;

    dc_sweep_sequencer_if #(.IDX_W(IW), .ADC_W(AW)) bus ();

    dc_sweep_sequencer #(.CODE_W(CW), .IDX_W(IW), .ADC_W(AW), .SET_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .vgs_start  (vgs_start),
        .vgs_step   (vgs_step),
        .vgs_num    (vgs_num),
        .vds_start  (vds_start),
        .vds_step   (vds_step),
        .vds_num    (vds_num),
        .settle_cyc (settle_cyc),
        .dac_vgs    (dac_vgs),
        .dac_vds    (dac_vds),
        .dac_load   (dac_load),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_miscmp = 0;
    logic [15:0] force_q[$];
    sweep_rec_t exp_rec[$];
    int         exp_vg[$];
    int         exp_vd[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Id = -I_probe in plain integers, clamped to the positive ADC range.
    function automatic logic [15:0] model_id(input logic [15:0] raw);
        int p;
        int v;
        p = $signed(raw);
        v = -p;
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction

    // Expected point list in sweep order; stops at the first code beyond 12 bits.
    task automatic build_model(input int vgs0, input int vgss, input int vgsn,
                               input int vds0, input int vdss, input int vdsn,
                               output bit ovf);
        sweep_rec_t r;
        int vg;
        int vd;
        exp_rec.delete();
        exp_vg.delete();
        exp_vd.delete();
        ovf = 1'b0;
        for (int g = 0; g < vgsn && !ovf; g++) begin
            for (int d = 0; d < vdsn && !ovf; d++) begin
                vg = vgs0 + g * vgss;
                vd = vds0 + d * vdss;
                if (vg > 4095 || vd > 4095) begin
                    ovf = 1'b1;
                end else begin
                    r.vgs_idx = 8'(g);
                    r.vds_idx = 8'(d);
                    r.id      = '0;
                    exp_rec.push_back(r);
                    exp_vg.push_back(vg);
                    exp_vd.push_back(vd);
                end
            end
        end
    endtask

    task automatic drive_cfg(input int vgs0, input int vgss, input int vgsn,
                             input int vds0, input int vdss, input int vdsn, input int settle);
        vgs_start  = CW'(vgs0);
        vgs_step   = CW'(vgss);
        vgs_num    = IW'(vgsn);
        vds_start  = CW'(vds0);
        vds_step   = CW'(vdss);
        vds_num    = IW'(vdsn);
        settle_cyc = SW'(settle);
    endtask

    // ready_mode: 0 always ready, 1 random ready + spurious acks, 2 stall 10 cycles at point 2.
    task automatic run_sweep(input int vgs0, input int vgss, input int vgsn,
                             input int vds0, input int vdss, input int vdsn,
                             input int settle, input int ack_dly, input int ready_mode,
                             input int abort_pt, input bit check_lat);
        bit          ovf, aborted;
        int          pt, loads, req_wait, stall_n, last_load, n_rec_exp, n_load_exp;
        logic [CW-1:0] prev_vg, prev_vd;
        logic [15:0] pend_id, raw;
        sweep_rec_t  r;
        build_model(vgs0, vgss, vgsn, vds0, vdss, vdsn, ovf);
        aborted = 0; pt = 0; loads = 0; req_wait = 0; stall_n = 0; last_load = -1;
        pend_id = '0;
        @(negedge clk);
        drive_cfg(vgs0, vgss, vgsn, vds0, vdss, vdsn, settle);
        start   = 1'b1;
        prev_vg = dac_vgs;
        prev_vd = dac_vds;
        @(negedge clk);
        start = 1'b0;
        if (vgsn == 0 || vdsn == 0) chk("start_done", {31'd0, done}, 32'd1);
        else                        chk("start_busy", {31'd0, busy}, 32'd1);
        for (int cyc = 0; cyc < Budget; cyc++) begin
            abort = 1'b0;
            // Shadowed config must ignore wandering inputs.
            drive_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            if (aborted) begin
                chk("abort_done", {31'd0, done}, 32'd1);
                chk("abort_req", {31'd0, bus.adc_req}, 32'd0);
                chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
                break;
            end
            if (done) break;
            if (dac_load) begin
                if (loads < exp_vg.size()) begin
                    chk("dac_vgs", 32'(dac_vgs), exp_vg[loads]);
                    chk("dac_vds", 32'(dac_vds), exp_vd[loads]);
                end else begin
                    chk("extra_load", loads, exp_vg.size());
                end
                if (check_lat && last_load >= 0) chk("latency", cyc - last_load, settle + 3);
                last_load = cyc;
                loads++;
                if (loads - 1 == abort_pt) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end else begin
                chk("dac_vgs_hold", 32'(dac_vgs), 32'(prev_vg));
                chk("dac_vds_hold", 32'(dac_vds), 32'(prev_vd));
            end
            prev_vg = dac_vgs;
            prev_vd = dac_vds;
            bus.adc_ack = 1'b0;
            if (bus.adc_req) begin
                if (req_wait == ack_dly) begin
                    if (force_q.size() > 0) raw = force_q.pop_front();
                    else                    raw = 16'($urandom);
                    bus.adc_data = raw;
                    bus.adc_ack  = 1'b1;
                    pend_id      = model_id(raw);
                    req_wait     = 0;
                end else begin
                    req_wait++;
                end
            end else if (ready_mode == 1) begin
                bus.adc_ack  = ($urandom_range(3) == 0);
                bus.adc_data = 16'($urandom);
            end
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(2) != 0);
                default: begin
                    if (bus.out_valid && pt == 2 && stall_n < 10) begin
                        bus.out_ready = 1'b0;
                        stall_n++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            if (bus.out_valid) begin
                if (pt < exp_rec.size()) begin
                    r = exp_rec[pt];
                    chk("vgs_idx", 32'(bus.out_vgs_idx), 32'(r.vgs_idx));
                    chk("vds_idx", 32'(bus.out_vds_idx), 32'(r.vds_idx));
                    chk("out_id", 32'(bus.out_id), 32'(pend_id));
                end else begin
                    chk("extra_rec", pt, exp_rec.size());
                end
                if (bus.out_ready) pt++;
            end
            @(negedge clk);
        end
        abort       = 1'b0;
        bus.adc_ack = 1'b0;
        n_rec_exp   = aborted ? abort_pt : exp_rec.size();
        n_load_exp  = aborted ? abort_pt + 1 : exp_vg.size();
        chk("sweep_done", {31'd0, done}, 32'd1);
        chk("n_records", pt, n_rec_exp);
        chk("n_loads", loads, n_load_exp);
        chk("err", {31'd0, err}, aborted ? 32'd0 : {31'd0, ovf});
        chk("busy_end", {31'd0, busy}, 32'd0);
        if (n_load_exp > 0) begin
            chk("dac_vgs_end", 32'(dac_vgs), exp_vg[n_load_exp-1]);
            chk("dac_vds_end", 32'(dac_vds), exp_vd[n_load_exp-1]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac_vgs"}, 32'(dac_vgs), 32'd0);
        chk({tag, "_dac_vds"}, 32'(dac_vds), 32'd0);
        chk({tag, "_dac_load"}, {31'd0, dac_load}, 32'd0);
        chk({tag, "_adc_req"}, {31'd0, bus.adc_req}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_out_vgs"}, 32'(bus.out_vgs_idx), 32'd0);
        chk({tag, "_out_vds"}, 32'(bus.out_vds_idx), 32'd0);
        chk({tag, "_out_id"}, 32'(bus.out_id), 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.adc_ack = 1'b0; bus.adc_data = '0; bus.out_ready = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // abort beats start in IDLE
        drive_cfg(0, 1, 2, 0, 1, 2, 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_done", {31'd0, done}, 32'd0);

        // 3x4 grid, settle 5, ack after 2 cycles
        run_sweep(0, 256, 3, 0, 512, 4, 5, 2, 0, -1, 1'b0);
        // per-point latency with immediate ack
        run_sweep(100, 7, 2, 200, 9, 3, 3, 0, 0, -1, 1'b1);
        run_sweep(5, 1, 1, 6, 1, 3, 0, 0, 0, -1, 1'b1);
        // negate / saturate corners
        force_q.push_back(16'h8000);
        force_q.push_back(16'hFF9C);
        force_q.push_back(16'h0001);
        run_sweep(16, 1, 1, 32, 1, 3, 0, 1, 0, -1, 1'b0);
        // vds code overflow after first point
        run_sweep(0, 0, 1, 'hF00, 'h100, 3, 1, 0, 0, -1, 1'b0);
        // vgs code overflow at row change
        run_sweep('hE00, 'h100, 4, 0, 1, 2, 0, 0, 0, -1, 1'b0);
        // sink stall at point 2
        run_sweep(1, 2, 2, 3, 4, 3, 2, 1, 2, -1, 1'b0);
        // abort in SETTLE of point 5, then clean rerun
        run_sweep(10, 20, 2, 30, 40, 4, 4, 1, 0, 5, 1'b0);
        run_sweep(10, 20, 2, 30, 40, 4, 4, 1, 0, -1, 1'b0);
        // empty axes
        run_sweep(0, 1, 0, 0, 1, 3, 2, 0, 0, -1, 1'b0);
        run_sweep(0, 1, 2, 0, 1, 0, 2, 0, 0, -1, 1'b0);

        // abort beats start in DONE
        @(negedge clk);
        drive_cfg(0, 1, 2, 0, 1, 2, 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("done_abort_busy", {31'd0, busy}, 32'd0);
        chk("done_abort_done", {31'd0, done}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_sweep($urandom_range(4095), ($urandom_range(1) != 0) ? $urandom_range(300) :
                      $urandom_range(4095), $urandom_range(4), $urandom_range(4095),
                      $urandom_range(400), $urandom_range(4, 1), $urandom_range(3),
                      $urandom_range(3), 1, -1, 1'b0);
        end

        // reset while converting
        run_sweep(3, 1, 1, 4, 1, 1, 0, 0, 0, -1, 1'b0);
        @(negedge clk);
        drive_cfg('h123, 1, 1, 'h234, 1, 2, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.adc_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_convert", {31'd0, bus.adc_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
